ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/kb_pkg.sv | 56 +++++
 rtl/ps2_rx_frame.sv | 122 ++++++++++++
 rtl/ps2_key_tracker.sv | 66 ++++++
 tb/tb_ps2_key_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Keyboard shared package: receiver states, scan codes and
// key-bit indices used by the tracker, debouncer and game logic.
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_UP    = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_Z     = 3'd5;
  localparam logic [2:0] KEY_X     = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  // Returns {hit, index}; the ext flag must match the mapped code
  function automatic logic [3:0] key_lookup(
    input logic [7:0] code,
    input logic       ext
  );
    logic [3:0] r;
    r = '0;
    case ({ext, code})
      {1'b1, SC_LEFT}:  r = {1'b1, KEY_LEFT};
      {1'b1, SC_RIGHT}: r = {1'b1, KEY_RIGHT};
      {1'b1, SC_DOWN}:  r = {1'b1, KEY_DOWN};
      {1'b1, SC_UP}:    r = {1'b1, KEY_UP};
      {1'b0, SC_SPACE}: r = {1'b1, KEY_SPACE};
      {1'b0, SC_Z}:     r = {1'b1, KEY_Z};
      {1'b0, SC_X}:     r = {1'b1, KEY_X};
      {1'b0, SC_P}:     r = {1'b1, KEY_P};
      default:          r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchroniser, falling-edge detect,
// start/data/parity/stop FSM and mid-frame idle timeout.
module ps2_rx_frame
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  rx_state_t     state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic          par_ok, par_ok_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [7:0]    byte_n;
  logic          valid_n;
  logic          err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      par_ok     <= 1'b0;
      tmo        <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      par_ok     <= par_ok_n;
      tmo        <= tmo_n;
      rx_byte    <= byte_n;
      byte_valid <= valid_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    par_ok_n = par_ok;
    byte_n   = rx_byte;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    tmo_n    = tmo;

    if (state == IDLE || fall) begin
      tmo_n = '0;
    end else if (tmo != TMAX) begin
      tmo_n = tmo + 1'b1;
    end

    // A stalled frame wins over a coincident edge
    if (state != IDLE && tmo == TMAX) begin
      state_n = IDLE;
      cnt_n   = '0;
      err_n   = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          if (!bit_in) state_n = DATA;
        end
        DATA: begin
          sh_n  = {bit_in, sh[7:1]};
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_ok_n = ^{sh, bit_in};
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (bit_in && par_ok) begin
            byte_n  = sh;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: decodes make/break/extended scan codes
// into a held-key vector for the game controls.
module ps2_key_tracker
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic       ext;
  logic       brk;
  logic       hit;
  logic [2:0] idx;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (scan_code),
    .byte_valid(scan_valid),
    .err       (frame_err)
  );

  assign {hit, idx} = key_lookup(scan_code, ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys <= '0;
      ext  <= 1'b0;
      brk  <= 1'b0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_valid) begin
      unique case (1'b1)
        scan_code == SC_EXT: ext <= 1'b1;
        scan_code == SC_BRK: brk <= 1'b1;
        (scan_code == SC_BAT_OK) ||
        (scan_code == SC_BAT_FAIL): begin
          keys <= '0;
          ext  <= 1'b0;
          brk  <= 1'b0;
        end
        default: begin
          if (hit) keys[idx] <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed PS/2 frames,
// expected events queued, monitor pops on scan_valid/frame_err.
module tb_ps2_key_tracker;

  localparam int TMO  = 2000;
  localparam int SYNC = 2;
  localparam int H    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  typedef struct {
    bit         err;
    logic [7:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  valid_cnt = 0;
  int  err_cnt = 0;

  ps2_key_tracker #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_valid) begin
        ev_t e;
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected scan_valid", {24'd0, scan_code}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event kind (valid)", {31'd0, e.err}, 32'd0);
          chk("scan_code", {24'd0, scan_code}, {24'd0, e.code});
        end
      end
      if (frame_err) begin
        ev_t e;
        err_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected frame_err", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event kind (err)", {31'd0, e.err}, 32'd1);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits < 11 leaves the frame unfinished with ps2_clk high
  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0,
                      input int nbits = 11);
    logic [10:0] bits;
    logic        par;
    par  = ~^b ^ bad_par;
    bits = {1'b1, par, b, 1'b0};
    if (nbits == 11) exp_q.push_back('{bad_par, b});
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(H);
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
    if (nbits == 11) begin
      ps2_data = 1'b1;
      wait_clk(2 * H);
    end
  endtask

  initial begin
    int v0, e0;
    wait_clk(3);
    chk("reset keys", {24'd0, keys}, 32'd0);
    chk("reset scan_code", {24'd0, scan_code}, 32'd0);
    chk("reset scan_valid", {31'd0, scan_valid}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(SYNC + 3);

    v0 = valid_cnt;
    send(8'h1A);
    chk("make Z", {24'd0, keys}, 32'h20);
    send(8'hF0);
    chk("F0 alone", {24'd0, keys}, 32'h20);
    send(8'h1A);
    chk("break Z", {24'd0, keys}, 32'h00);
    chk("valid pulses Z", valid_cnt - v0, 32'd3);

    send(8'hE0); send(8'h6B);
    chk("make Left", {24'd0, keys}, 32'h01);
    send(8'hE0); send(8'h74);
    chk("make Right", {24'd0, keys}, 32'h03);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("break Left", {24'd0, keys}, 32'h02);

    v0 = valid_cnt;
    send(8'h6B);
    chk("6B no ext keys", {24'd0, keys}, 32'h02);
    chk("6B no ext code", {24'd0, scan_code}, 32'h6B);
    chk("6B no ext valid", valid_cnt - v0, 32'd1);

    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back('{1'b1, 8'h00});
    exp_q.pop_back();
    send(8'h29, 1'b1);
    chk("bad parity err", err_cnt - e0, 32'd1);
    chk("bad parity valid", valid_cnt - v0, 32'd0);
    chk("bad parity keys", {24'd0, keys}, 32'h02);

    send(8'hE0); send(8'hF0); send(8'h74);
    chk("break Right", {24'd0, keys}, 32'h00);

    e0 = err_cnt;
    exp_q.push_back('{1'b1, 8'h00});
    send(8'h29, 1'b0, 5);
    ps2_data = 1'b1;
    wait_clk(TMO - 20);
    chk("no early timeout", err_cnt - e0, 32'd0);
    wait_clk(60);
    chk("timeout err once", err_cnt - e0, 32'd1);
    chk("timeout keys", {24'd0, keys}, 32'h00);
    send(8'h29);
    chk("space after tmo", {24'd0, keys}, 32'h10);
    send(8'h29);
    chk("typematic", {24'd0, keys}, 32'h10);

    send(8'hE0); send(8'h6B);
    chk("hold 0x11", {24'd0, keys}, 32'h11);
    e0 = err_cnt;
    send(8'h22, 1'b0, 4);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async reset keys", {24'd0, keys}, 32'd0);
    wait_clk(4);
    ps2_data = 1'b1;
    rst_n = 1'b1;
    wait_clk(TMO + 50);
    chk("no err after reset", err_cnt - e0, 32'd0);
    send(8'h1A);
    chk("rx after reset", {24'd0, keys}, 32'h20);

    send(8'hE0); send(8'hAA);
    chk("BAT clears keys", {24'd0, keys}, 32'h00);
    send(8'h6B);
    chk("BAT clears ext", {24'd0, keys}, 32'h00);

    wait_clk(10);
    chk("queue drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
